// File: rtl/path_mailbox_pkg.sv
// Shared constants and types for the path-planning mailbox peripheral.
package path_mailbox_pkg;

    localparam logic [3:0] OFF_START = 4'h0;
    localparam logic [3:0] OFF_END   = 4'h4;
    localparam logic [3:0] OFF_NODE  = 4'h8;
    localparam logic [3:0] OFF_DONE  = 4'hC;

    localparam int NODE_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/path_mailbox_if.sv
// Bus bundle between the mailbox and its surroundings: host/CPU write ports,
// CPU load data and the node stream.
interface path_mailbox_if
    import path_mailbox_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEF,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              Ext_MemWrite;
    logic [31:0]       Ext_DataAdr;
    logic [31:0]       Ext_WriteData;
    logic              MemWrite;
    logic [31:0]       DataAdr;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;
    logic              node_valid;
    logic [NODE_W-1:0] node_data;
    logic              node_ready;
    logic [CNT_W-1:0]  node_count;
    logic              overflow;
    logic              done;
    state_e            dbg_state;

    // Node stream: a transfer happens on a rising edge where node_valid && node_ready;
    // node_data is stable while node_valid is high and ready may toggle freely.
    modport master (
        output Ext_MemWrite, Ext_DataAdr, Ext_WriteData,
        output MemWrite, DataAdr, WriteData, node_ready,
        input  ReadData, node_valid, node_data, node_count, overflow, done, dbg_state
    );

    modport slave (
        input  Ext_MemWrite, Ext_DataAdr, Ext_WriteData,
        input  MemWrite, DataAdr, WriteData, node_ready,
        output ReadData, node_valid, node_data, node_count, overflow, done, dbg_state
    );

endinterface

// File: rtl/path_mailbox_sync_fifo.sv
// Synchronous FIFO with separate occupancy counter; a push into a full FIFO is
// accepted when a pop happens in the same cycle, otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        head  = empty ? '0 : mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/path_mailbox.sv
// Memory-mapped responder for the path-planning handshake: START/END loaded by
// the host during reset, NODE reports buffered in a FIFO, CPU_DONE ends the run.
module path_mailbox
    import path_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          DEPTH     = 16,
    parameter int          NODE_W    = NODE_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    path_mailbox_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [NODE_W-1:0] start_q, start_d;
    logic [NODE_W-1:0] end_q, end_d;
    logic [NODE_W-1:0] last_node_q, last_node_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic              cpu_hit, ext_hit, node_wr, done_wr;
    logic              push_drop, fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              unused_ok;

    assign unused_ok = ^{bus.Ext_WriteData[31:NODE_W], fifo_full};

    always_comb begin
        cpu_hit = (bus.DataAdr[31:4] == BASE_ADDR[31:4]) && (bus.DataAdr[1:0] == 2'b00);
        ext_hit = (bus.Ext_DataAdr[31:4] == BASE_ADDR[31:4]) && (bus.Ext_DataAdr[1:0] == 2'b00);
        node_wr = bus.MemWrite && cpu_hit && (bus.DataAdr[3:0] == OFF_NODE) && (state_q == RUN);
        done_wr = bus.MemWrite && cpu_hit && (bus.DataAdr[3:0] == OFF_DONE) &&
                  (bus.WriteData == 32'd1) && (state_q == RUN);
    end

    sync_fifo #(.WIDTH(NODE_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (node_wr),
        .push_data (bus.WriteData[NODE_W-1:0]),
        .pop       (bus.node_ready),
        .head      (bus.node_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .drop      (push_drop)
    );

    // START/END only load from the host while the CPU is held in reset.
    always_comb begin
        start_d = start_q;
        end_d   = end_q;
        if (reset && bus.Ext_MemWrite && ext_hit) begin
            if (bus.Ext_DataAdr[3:0] == OFF_START) start_d = bus.Ext_WriteData[NODE_W-1:0];
            if (bus.Ext_DataAdr[3:0] == OFF_END)   end_d   = bus.Ext_WriteData[NODE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        start_q <= start_d;
        end_q   <= end_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (done_wr) state_d = DRAIN;
            DRAIN:   if (fifo_count == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
        last_node_d = node_wr ? bus.WriteData[NODE_W-1:0] : last_node_q;
        overflow_d  = overflow_q || push_drop;
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            last_node_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_node_q <= last_node_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        bus.ReadData = '0;
        if (cpu_hit) begin
            case (bus.DataAdr[3:0])
                OFF_START: bus.ReadData = 32'(start_q);
                OFF_END:   bus.ReadData = 32'(end_q);
                OFF_NODE:  bus.ReadData = 32'(last_node_q);
                OFF_DONE:  bus.ReadData = {31'b0, state_q != RUN};
                default:   bus.ReadData = '0;
            endcase
        end
    end

    assign bus.node_valid = !fifo_empty;
    assign bus.node_count = fifo_count;
    assign bus.overflow   = overflow_q;
    assign bus.done       = done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_path_mailbox.sv
// Directed bench for path_mailbox: register window, node stream ordering,
// overflow, drain/done sequencing and mid-run reset.
module tb_path_mailbox;
  import path_mailbox_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_START = BASE + 32'h0;
  localparam logic [31:0] A_END   = BASE + 32'h4;
  localparam logic [31:0] A_NODE  = BASE + 32'h8;
  localparam logic [31:0] A_DONE  = BASE + 32'hC;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [4:0] exp_q[$];

  path_mailbox_if #(.NODE_W(5), .DEPTH(16)) bus ();

  path_mailbox #(.BASE_ADDR(BASE), .DEPTH(16), .NODE_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted pop must match the queue head
  always @(negedge clk) begin
    if (!reset && bus.node_valid && bus.node_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0d expected no data", bus.node_data);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check(32'(bus.node_data), 32'(e), "pop_data");
      end
    end
  end

  // driver tasks: all start and end #1 after a rising edge
  task automatic ext_write(input logic [31:0] addr, input logic [31:0] data);
    bus.Ext_MemWrite  = 1'b1;
    bus.Ext_DataAdr   = addr;
    bus.Ext_WriteData = data;
    @(posedge clk); #1;
    bus.Ext_MemWrite  = 1'b0;
  endtask

  task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = addr;
    bus.WriteData = data;
    @(posedge clk); #1;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
  endtask

  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus.DataAdr = addr;
    #1;
    check(bus.ReadData, exp, name);
    bus.DataAdr = '0;
  endtask

  task automatic drain_all(input string name);
    int cyc;
    cyc = 0;
    bus.node_ready = 1'b1;
    while (bus.node_count != 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.node_ready = 1'b0;
    check(32'(bus.node_count), 32'd0, name);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.Ext_MemWrite = 1'b0; bus.Ext_DataAdr = '0; bus.Ext_WriteData = '0;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    bus.node_ready = 1'b0;

    // host load during reset
    @(posedge clk); #1;
    ext_write(A_START, 32'd3);
    ext_write(A_END, 32'd9);
    ext_write(A_NODE, 32'd21);
    check(32'(bus.node_valid), 32'd0, "rst_valid");
    check(32'(bus.node_data), 32'd0, "rst_data");
    check(32'(bus.node_count), 32'd0, "rst_count");
    check(32'(bus.overflow), 32'd0, "rst_overflow");
    check(32'(bus.done), 32'd0, "rst_done");
    check(32'(bus.dbg_state), 32'(RUN), "rst_state");
    reset = 1'b0;

    cpu_read(A_START, 32'd3, "rd_start");
    cpu_read(A_END, 32'd9, "rd_end");
    cpu_read(A_NODE, 32'd0, "rd_last_rst");
    cpu_read(A_DONE, 32'd0, "rd_done_run");
    cpu_read(BASE + 32'h1, 32'd0, "rd_misaligned");
    cpu_read(BASE + 32'h10, 32'd0, "rd_miss");
    ext_write(A_START, 32'd5);
    cpu_read(A_START, 32'd3, "start_ext_ignored");
    cpu_store(A_END, 32'd7);
    cpu_read(A_END, 32'd9, "end_cpu_ignored");

    // three nodes, then stream them out
    cpu_store(A_NODE, 32'd3); exp_q.push_back(5'd3);
    check(32'(bus.node_valid), 32'd1, "push_visible");
    cpu_store(A_NODE, 32'd7); exp_q.push_back(5'd7);
    cpu_store(A_NODE, 32'd9); exp_q.push_back(5'd9);
    check(32'(bus.node_count), 32'd3, "count3");
    check(32'(bus.node_data), 32'd3, "head3");
    cpu_read(A_NODE, 32'd9, "last_node");
    bus.node_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.node_ready = 1'b0;
    check(32'(bus.node_valid), 32'd0, "stream_empty");
    check(32'(bus.node_count), 32'd0, "stream_count0");

    // overflow: 17 stores, 17th dropped
    for (int i = 1; i <= 17; i++) begin
      cpu_store(A_NODE, 32'(i));
      if (i <= 16) exp_q.push_back(5'(i));
    end
    check(32'(bus.node_count), 32'd16, "full_count");
    check(32'(bus.overflow), 32'd1, "overflow_set");
    check(32'(bus.node_data), 32'd1, "full_head");
    // push+pop while full: accepted, count unchanged
    bus.node_ready = 1'b1;
    exp_q.push_back(5'd20);
    cpu_store(A_NODE, 32'd20);
    bus.node_ready = 1'b0;
    check(32'(bus.node_count), 32'd16, "full_pushpop_count");
    check(32'(bus.node_data), 32'd2, "full_pushpop_head");
    drain_all("full_drain");
    check(32'(exp_q.size()), 32'd0, "full_sb_empty");
    check(32'(bus.overflow), 32'd1, "overflow_sticky");

    // drain / done sequencing
    cpu_store(A_NODE, 32'd11); exp_q.push_back(5'd11);
    cpu_store(A_NODE, 32'd12); exp_q.push_back(5'd12);
    cpu_store(A_DONE, 32'd1);
    check(32'(bus.done), 32'd0, "drain_done0");
    check(32'(bus.dbg_state), 32'(DRAIN), "drain_state");
    cpu_read(A_DONE, 32'd1, "rd_done_drain");
    cpu_store(A_NODE, 32'd13);
    check(32'(bus.node_count), 32'd2, "drain_store_ignored");
    cpu_read(A_NODE, 32'd12, "drain_last_kept");
    bus.node_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.node_ready = 1'b0;
    check(32'(bus.node_count), 32'd0, "drain_popped");
    check(32'(bus.done), 32'd0, "done_not_yet");
    @(posedge clk); #1;
    check(32'(bus.done), 32'd1, "done_rise");
    check(32'(bus.dbg_state), 32'(DONE), "done_state");
    cpu_store(A_NODE, 32'd14);
    check(32'(bus.node_count), 32'd0, "done_store_ignored");

    // CPU_DONE with wrong value, then with empty FIFO
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check(32'(bus.done), 32'd0, "reset_clears_done");
    cpu_store(A_DONE, 32'd2);
    @(posedge clk); #1;
    check(32'(bus.dbg_state), 32'(RUN), "done2_state");
    check(32'(bus.done), 32'd0, "done2_done");
    cpu_read(A_DONE, 32'd0, "done2_rd");
    cpu_store(A_NODE, 32'd6); exp_q.push_back(5'd6);
    check(32'(bus.node_count), 32'd1, "done2_still_run");
    drain_all("done2_drain");
    cpu_store(A_DONE, 32'd1);
    check(32'(bus.done), 32'd0, "empty_done_1cyc");
    @(posedge clk); #1;
    check(32'(bus.done), 32'd1, "empty_done_2cyc");

    // reset mid-operation with 5 nodes and overflow
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpu_store(A_NODE, 32'(i + 4));
      if (i < 16) exp_q.push_back(5'(i + 4));
    end
    bus.node_ready = 1'b1;
    repeat (11) begin @(posedge clk); #1; end
    bus.node_ready = 1'b0;
    check(32'(bus.node_count), 32'd5, "pre_reset_count");
    check(32'(bus.overflow), 32'd1, "pre_reset_overflow");
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check(32'(bus.node_count), 32'd0, "midrst_count");
    check(32'(bus.node_valid), 32'd0, "midrst_valid");
    check(32'(bus.overflow), 32'd0, "midrst_overflow");
    check(32'(bus.done), 32'd0, "midrst_done");
    cpu_read(A_START, 32'd3, "midrst_start");
    cpu_read(A_END, 32'd9, "midrst_end");
    cpu_read(A_NODE, 32'd0, "midrst_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/path_mailbox.md
# path_mailbox

Memory-mapped mailbox peripheral at 0x0200_0000 on the RV32I data bus. It is the responder end of the path-planning handshake. The host loads START_POINT and END_POINT through the external write port while the CPU is held in reset. The CPU then reports each NODE_POINT and finally CPU_DONE through ordinary stores; reported nodes are buffered in a FIFO and drained by the host or checker through a valid/ready stream.

## Interface
- BASE_ADDR, 32'h0200_0000, base of the 16-byte register window
- DEPTH, 16, node FIFO depth (power of two)
- NODE_W, 5, node identifier width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- Ext_MemWrite  in  1  host write strobe (honoured only while reset=1)
- Ext_DataAdr  in  32  host write address
- Ext_WriteData  in  32  host write data
- MemWrite  in  1  CPU store strobe
- DataAdr  in  32  CPU data address
- WriteData  in  32  CPU store data
- ReadData  out  32  CPU load data, combinational from registers
- node_valid  out  1  FIFO non-empty
- node_data  out  NODE_W  FIFO head
- node_ready  in  1  consumer pop request
- node_count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky, a node was dropped
- done  out  1  CPU finished and FIFO drained

## Operation
- Register offsets: 0x0 START, 0x4 END, 0x8 NODE, 0xC CPU_DONE. A hit requires DataAdr[31:4]==BASE_ADDR[31:4] and DataAdr[1:0]==0.
- START/END: NODE_W-bit registers, not cleared by reset. They load from Ext_WriteData[NODE_W-1:0] when reset=1 && Ext_MemWrite && address hit. Ext writes to 0x8/0xC, and all Ext writes while reset=0, are ignored. CPU stores to START/END are ignored.
- NODE store (state RUN): pushes WriteData[NODE_W-1:0] into the FIFO and updates LAST_NODE (reset 0).
  - If the FIFO is full and no pop occurs in that cycle, the push is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- CPU_DONE store with WriteData==1 in RUN: transition RUN→DRAIN. Any other value is ignored.
- ReadData by offset:
  - 0x0 → START zero-extended
  - 0x4 → END zero-extended
  - 0x8 → LAST_NODE zero-extended
  - 0xC → {31'b0, state!=RUN}
  - miss → 0
- FSM states:
  - RUN (reset state): accepts NODE pushes.
  - DRAIN: NODE stores ignored; goes to DONE when the registered node_count==0.
  - DONE: NODE and CPU_DONE stores ignored; left only by reset.
- Pop: node_valid && node_ready removes the head. node_ready while empty has no effect.

## Timing
- Reset values: node_valid 0, node_data 0, node_count 0, overflow 0, done 0, state RUN, FIFO pointers 0. ReadData reflects cleared registers.
- Push-to-visible latency is 1 cycle: a store at edge N gives node_valid=1 and node_data=value after edge N.
- Pop takes effect at the edge; the next head appears in the same cycle.
- node_count updates at the edge: +1 push only, -1 pop only, unchanged for simultaneous push+pop or a dropped push.
- DRAIN occupies at least 1 cycle. done rises 1 cycle after node_count reaches 0.
- Reset mid-operation: FIFO, overflow, done, LAST_NODE and state clear in one cycle. START/END are retained unless rewritten during that reset.
- Pointers wrap modulo DEPTH; occupancy is kept as a separate counter.

## Structure
- Package path_mailbox_pkg holds:
  - offset constants OFF_START/OFF_END/OFF_NODE/OFF_DONE
  - state enum {RUN, DRAIN, DONE}
  - default NODE_W
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count. Full-with-pop acceptance is implemented inside sync_fifo.

## Test plan
- Reset=1, Ext writes 0x02000000←3 and 0x02000004←9, then release → CPU loads return 3 and 9. Ext write to 0x02000000 after release → START remains 3.
- With node_ready=0, CPU stores 3, 7, 9 to 0x02000008 → node_count=3, node_data=3. Raise node_ready → stream 3, 7, 9 on consecutive cycles, then node_valid=0.
- 17 NODE stores with no pops → node_count=16, overflow=1, the 17th value is absent. Then push+pop in the same cycle while full → count stays 16 and the new value lands at the tail.
- Two nodes queued, then CPU_DONE←1 → done=0 until both are popped; done=1 one cycle after the last pop. A NODE store while in DRAIN → count unchanged.
- CPU_DONE←2 → state stays RUN and done=0. CPU_DONE←1 with an empty FIFO → done=1 two cycles later.
- Assert reset with 5 nodes queued and overflow=1 → next cycle count=0, overflow=0, done=0, and START/END are preserved.
